// File: rtl/des_key_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
//   Shared types and constants for the DES key schedule blocks (sequencer,
//   key generator, round datapath).
//   - state_t    : sequencer FSM states
//   - DES_ROUNDS : rounds per key pass
//   - DES_KEYS   : key passes per triple-DES block
//   - ROUND_W    : width of round_count (holds 0..DES_ROUNDS)
//   - KEY_W      : width of key_count (holds 0..DES_KEYS-1)
//   - SUBKEY_W   : width of the subkey round index (0..DES_ROUNDS-1)
// -----------------------------------------------------------------------------
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DES_ROUNDS = 16;
    localparam int DES_KEYS   = 3;
    localparam int ROUND_W    = 5;
    localparam int KEY_W      = 2;
    localparam int SUBKEY_W   = 4;

endpackage

// File: rtl/des_key_sequencer_if.sv
// -----------------------------------------------------------------------------
// des_key_sequencer_if
//   Bundle between the block controller / key generator / round datapath and
//   the key sequencer.
//   master : block controller side (drives start, reverse_in, hold; observes
//            everything the sequencer produces)
//   slave  : sequencer side
//   Signals:
//     start, reverse_in, hold        - requests from the controller/datapath
//     busy, done, reverse            - block-level status
//     key_enable, round_count,
//     key_count, cnt_rollover,
//     key_rollover                   - key generator controls
//     subkey_valid, subkey_round     - subkey qualification for the datapath
// -----------------------------------------------------------------------------
interface des_key_sequencer_if;
    import des_pkg::*;

    logic                start;
    logic                reverse_in;
    logic                hold;
    logic                busy;
    logic                done;
    logic                reverse;
    logic                key_enable;
    logic [ROUND_W-1:0]  round_count;
    logic [KEY_W-1:0]    key_count;
    logic                cnt_rollover;
    logic                key_rollover;
    logic                subkey_valid;
    logic [SUBKEY_W-1:0] subkey_round;

    modport master (
        output start, reverse_in, hold,
        input  busy, done, reverse, key_enable, round_count, key_count,
        input  cnt_rollover, key_rollover, subkey_valid, subkey_round
    );

    modport slave (
        input  start, reverse_in, hold,
        output busy, done, reverse, key_enable, round_count, key_count,
        output cnt_rollover, key_rollover, subkey_valid, subkey_round
    );

endinterface

// File: rtl/des_key_sequencer_sync_counter.sv
// -----------------------------------------------------------------------------
// sync_counter
//   Up counter 0..MAX with wrap to 0.
//   Ports:
//     clk     - clock
//     rst     - synchronous active-high reset
//     clr_i   - synchronous clear (same effect as rst, used for run restart)
//     en_i    - count enable
//     count_o - current count
//     roll_o  - high when counting from MAX this cycle (en_i && count==MAX)
// -----------------------------------------------------------------------------
module sync_counter #(
    parameter int WIDTH = 5,
    parameter int MAX   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             roll_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign roll_o  = en_i && (cnt_q == MAX_V);
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = roll_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/des_key_sequencer.sv
// -----------------------------------------------------------------------------
// des_key_sequencer
//   Walks NUM_KEYS key passes (one LOAD cycle + NUM_ROUNDS round cycles each)
//   for one triple-DES block and drives the key generator controls plus
//   subkey qualification for the Feistel datapath.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset (abandons any run, no done pulse)
//     bus  - des_key_sequencer_if.slave (handshake, key generator controls,
//            subkey valid/round)
//   Parameters:
//     NUM_ROUNDS - rounds per key pass
//     NUM_KEYS   - key passes per block
// -----------------------------------------------------------------------------
module des_key_sequencer
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS,
    parameter int NUM_KEYS   = DES_KEYS
) (
    input logic               clk,
    input logic               rst,
    des_key_sequencer_if.slave bus
);

    state_t              state_q, state_d;
    logic                reverse_q, reverse_d;
    logic                subkey_valid_q, subkey_valid_d;
    logic [SUBKEY_W-1:0] subkey_round_q, subkey_round_d;

    logic                run_active;
    logic                key_enable;
    logic                start_acc;
    logic [ROUND_W-1:0]  round_count;
    logic [KEY_W-1:0]    key_count;
    logic                cnt_roll;
    logic                key_roll;

    assign run_active = (state_q == LOAD) || (state_q == ROUND);
    // hold freezes the sequence by killing the enable, which in turn gates
    // both counters and both rollover strobes.
    assign key_enable = run_active && !bus.hold;
    assign start_acc  = (state_q == IDLE) && bus.start;

    // Round counter: 0 in LOAD, 1..NUM_ROUNDS in ROUND, wraps back to 0 on
    // the rollover cycle so the next LOAD sees 0.
    sync_counter #(
        .WIDTH (ROUND_W),
        .MAX   (NUM_ROUNDS)
    ) u_round_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_acc),
        .en_i    (key_enable),
        .count_o (round_count),
        .roll_o  (cnt_roll)
    );

    // Key counter advances on each round rollover; its own rollover on the
    // last pass is key_rollover and leaves it back at 0.
    sync_counter #(
        .WIDTH (KEY_W),
        .MAX   (NUM_KEYS - 1)
    ) u_key_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_acc),
        .en_i    (cnt_roll),
        .count_o (key_count),
        .roll_o  (key_roll)
    );

    always_comb begin
        state_d   = state_q;
        reverse_d = reverse_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = LOAD;
                    reverse_d = bus.reverse_in;
                end
            end
            LOAD: begin
                if (!bus.hold) state_d = ROUND;
            end
            ROUND: begin
                if (key_roll)      state_d = DONE;
                else if (cnt_roll) state_d = LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The key generator registers the subkey on key_enable, so the subkey for
    // round r (round_count = r+1) is usable one cycle later.
    always_comb begin
        subkey_valid_d = key_enable && (round_count != '0);
        subkey_round_d = '0;
        if (subkey_valid_d) subkey_round_d = SUBKEY_W'(round_count - ROUND_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            reverse_q      <= 1'b0;
            subkey_valid_q <= 1'b0;
            subkey_round_q <= '0;
        end else begin
            state_q        <= state_d;
            reverse_q      <= reverse_d;
            subkey_valid_q <= subkey_valid_d;
            subkey_round_q <= subkey_round_d;
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.reverse      = reverse_q;
    assign bus.key_enable   = key_enable;
    assign bus.round_count  = round_count;
    assign bus.key_count    = key_count;
    assign bus.cnt_rollover = cnt_roll;
    assign bus.key_rollover = key_roll;
    assign bus.subkey_valid = subkey_valid_q;
    assign bus.subkey_round = subkey_round_q;

endmodule

// File: tb/tb_des_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_des_key_sequencer
//   Directed bench for des_key_sequencer. Cycle 0 is the cycle in which start
//   is presented; expected outputs per cycle come from the documented run
//   timing (LOAD at 1/18/35, round 16 at 17/34/51, DONE at 52), shifted by any
//   injected hold cycles.
// -----------------------------------------------------------------------------
module tb_des_key_sequencer;
    import des_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    des_key_sequencer_if bus_if ();

    des_key_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // {busy,done,reverse,key_enable,round_count,key_count,cnt_ro,key_ro,sv,sr}
    logic [17:0] vec;
    assign vec = {bus_if.busy, bus_if.done, bus_if.reverse, bus_if.key_enable,
                  bus_if.round_count, bus_if.key_count, bus_if.cnt_rollover,
                  bus_if.key_rollover, bus_if.subkey_valid, bus_if.subkey_round};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output vector at effective cycle e of an unheld run.
    // held: this cycle is stalled; ph: previous cycle was stalled.
    function automatic logic [17:0] expv(int e, bit rev, bit held, bit ph);
        logic       busy, done, ke, cr, kr, sv;
        logic [4:0] rc;
        logic [1:0] kc;
        logic [3:0] sr;
        int         p, pos, pp;
        busy = 0; done = 0; ke = 0; cr = 0; kr = 0; sv = 0;
        rc = '0; kc = '0; sr = '0;
        if (e >= 1 && e <= 51) begin
            p    = (e - 1) / 17;
            pos  = (e - 1) % 17;
            busy = 1;
            ke   = !held;
            rc   = 5'(pos);
            kc   = 2'(p);
            cr   = !held && (pos == 16);
            kr   = cr && (p == 2);
        end else if (e == 52) begin
            busy = 1;
            done = 1;
        end
        if (!ph && (e - 1) >= 1 && (e - 1) <= 51) begin
            pp = (e - 2) % 17;
            if (pp != 0) begin
                sv = 1;
                sr = 4'(pp - 1);
            end
        end
        return {busy, done, rev, ke, rc, kc, cr, kr, sv, sr};
    endfunction

    // One block: start at cycle 0, optional hold window [h_at, h_at+h_len),
    // optional hold in the DONE cycle, optional spurious starts at 10 and DONE.
    task automatic run(input string name, input bit rev, input int h_at, input int h_len,
                       input bit h_done, input bit spur);
        int e, ndone, nsv, ncr, nkr;
        bit held, ph;
        ndone = 0; nsv = 0; ncr = 0; nkr = 0;
        bus_if.start      = 1'b1;
        bus_if.reverse_in = rev;
        bus_if.hold       = 1'b0;
        step();
        bus_if.start      = 1'b0;
        bus_if.reverse_in = !rev;
        for (int c = 1; c <= 54 + h_len; c++) begin
            held = (h_len > 0) && (c >= h_at) && (c < h_at + h_len);
            ph   = (h_len > 0) && (c - 1 >= h_at) && (c - 1 < h_at + h_len);
            e    = (h_len == 0 || c < h_at) ? c : (held ? h_at : c - h_len);
            bus_if.hold  = held || (h_done && c == 52 + h_len);
            bus_if.start = spur && (c == 10 || c == 52 + h_len);
            #1;
            chk($sformatf("%s_c%0d", name, c), 32'(vec), 32'(expv(e, rev, held, ph)));
            if (bus_if.done)         ndone++;
            if (bus_if.subkey_valid) nsv++;
            if (bus_if.cnt_rollover) ncr++;
            if (bus_if.key_rollover) nkr++;
            step();
        end
        bus_if.hold  = 1'b0;
        bus_if.start = 1'b0;
        chk({name, "_ndone"}, 32'(ndone), 32'd1);
        chk({name, "_nsv"},   32'(nsv),   32'd48);
        chk({name, "_ncro"},  32'(ncr),   32'd3);
        chk({name, "_nkro"},  32'(nkr),   32'd1);
    endtask

    initial begin
        int nd;
        rst               = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.reverse_in = 1'b0;
        bus_if.hold       = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_outs", 32'(vec), 32'd0);

        // start and rst together: reset wins, nothing queued
        rst               = 1'b1;
        bus_if.start      = 1'b1;
        bus_if.reverse_in = 1'b1;
        step();
        rst          = 1'b0;
        bus_if.start = 1'b0;
        #1;
        chk("rst_start_c1", 32'(vec), 32'd0);
        step();
        chk("rst_start_c2", 32'(vec), 32'd0);

        run("enc",    1'b0, 0,  0, 1'b0, 1'b0);
        run("dec",    1'b1, 0,  0, 1'b1, 1'b0);
        run("hold7",  1'b0, 25, 3, 1'b0, 1'b0);
        run("hold16", 1'b1, 51, 1, 1'b0, 1'b0);

        // abort with rst in cycle 25 of a decrypt run
        bus_if.start      = 1'b1;
        bus_if.reverse_in = 1'b1;
        step();
        bus_if.start = 1'b0;
        repeat (24) step();
        chk("abort_c25", 32'(vec), 32'(expv(25, 1'b1, 1'b0, 1'b0)));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_c26", 32'(vec), 32'd0);
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            if (bus_if.done || bus_if.busy) nd++;
            step();
        end
        chk("abort_quiet", 32'(nd), 32'd0);

        run("spur",  1'b0, 0, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/des_key_sequencer.md
# des_key_sequencer

Control-side sequencer that drives the DES subkey schedule for one triple-DES block. On `start` it walks three key passes of one load cycle plus 16 round cycles each, and generates `key_enable`, `round_count`, `key_count`, `cnt_rollover`, `key_rollover` and `reverse` for the key generator. It also tells the Feistel datapath when each registered subkey is valid and which round it belongs to. It sits between the block-level controller (start/done handshake) and the key generator / round datapath pair.

## Interface
- `NUM_ROUNDS`, default 16: rounds per key pass; `round_count` runs 0..`NUM_ROUNDS`.
- `NUM_KEYS`, default 3: key passes per block; `key_count` runs 0..`NUM_KEYS`-1.
- `clk` input 1: system clock. One clock; reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to process one block. Sampled only in IDLE.
- `reverse_in` input 1: 0 = encrypt order, 1 = decrypt order. Latched when `start` is accepted.
- `hold` input 1: datapath stall. Freezes the sequence while high.
- `busy` output 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` output 1: one-cycle pulse when the block's schedule completes.
- `reverse` output 1: latched direction, stable for the whole run.
- `key_enable` output 1: subkey register update enable.
- `round_count` output 5: 0 = load the key pass; 1..16 = round shift.
- `key_count` output 2: current key pass, 0..2.
- `cnt_rollover` output 1: high in the cycle where `round_count`=16 and `key_enable`=1.
- `key_rollover` output 1: high in the cycle where `cnt_rollover`=1 and `key_count`=2.
- `subkey_valid` output 1: key generator's subkey output is valid for the datapath this cycle.
- `subkey_round` output 4: round index 0..15 of the valid subkey.

## Operation
- States: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - `start`=1: latch `reverse_in`, clear `key_count`, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `key_enable`=1, `round_count`=0 (key generator loads PC-1 of the next key).
  - Go to ROUND with `round_count`=1.
- ROUND:
  - `key_enable`=1 and `round_count` increments 1..16.
  - At 16 with `key_count`<2: assert `cnt_rollover`, increment `key_count`, go to LOAD.
  - At 16 with `key_count`=2: assert `cnt_rollover` and `key_rollover`, clear `key_count` to 0, go to DONE.
- DONE:
  - `done`=1, `busy`=1 for one cycle, then go to IDLE.
- `hold`=1 in LOAD or ROUND:
  - `key_enable`, `cnt_rollover` and `key_rollover` are forced to 0.
  - State, `round_count` and `key_count` are frozen.
  - Rollover strobes fire only on the non-held cycle.
- `subkey_valid` is a register of (`key_enable` and `round_count`≠0). `subkey_round` is a register of `round_count`−1.
- `key_count` does not depend on direction; the key generator applies the ordering from `reverse`.
- `start` while `busy`=1 is ignored and not queued.
- `reverse` changes only on an accepted `start`.

## Timing
- Reset values: state IDLE; all outputs 0, including `reverse`, `round_count`, `key_count` and `subkey_round`.
- `rst` mid-run: the next cycle is IDLE with all outputs 0 and no `done` pulse. The run is abandoned.
- `start` accepted at cycle 0 with no holds:
  - LOAD at cycles 1, 18, 35.
  - `round_count`=16 at cycles 17, 34, 51.
  - `subkey_valid` at cycles 3–18, 20–35, 37–52.
  - DONE/`done` at cycle 52; IDLE at cycle 53.
- Total run is 52 cycles plus the number of held cycles.
- A new `start` is accepted at cycle 53 at the earliest.
- `start` and `rst` in the same cycle: `rst` wins.
- `hold` asserted in the DONE cycle has no effect.

## Structure
- Shared package `des_pkg` holds:
  - `state_t` enum (IDLE, LOAD, ROUND, DONE).
  - Constants `DES_ROUNDS`=16 and `DES_KEYS`=3, which are also used by the key generator and datapath.
  - `ROUND_W`=5 and `KEY_W`=2.
- One sub-module, `sync_counter`:
  - Parameterised width and rollover value.
  - Inputs: synchronous active-high clear, count enable.
  - Outputs: count value, rollover flag.
  - Instantiated twice: round counter and key counter.
- FSM and output registers live in the top.

## Test plan
- Reset, then `start`=1 with `reverse_in`=0, no hold:
  - `round_count` sequence 0,1..16 repeated three times.
  - `cnt_rollover` at cycles 17/34/51; `key_rollover` at 51 only.
  - `done` at 52; `subkey_valid` count = 48.
- `start` with `reverse_in`=1: same timing, `reverse`=1 for cycles 1–52; `key_count` still 0,1,2.
- `hold`=1 for 3 cycles while `round_count`=7 on key 1:
  - `round_count` holds 7 and `key_enable`=0 for 3 cycles; `subkey_valid` drops for 3 cycles.
  - `done` moves to cycle 55.
- `hold`=1 in the cycle where `round_count`=16 on key 2: no rollover that cycle; `key_rollover` fires on release.
- `rst` at cycle 25: the next cycle shows IDLE, all outputs 0, no `done`. A new `start` runs the full 52 cycles.
- `start` pulsed at cycles 10 and 52 of a run: ignored; exactly one `done`.
